// File: rtl/apb_mst_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mst_bridge
//  Purpose  : APB4 requester. Turns a valid/ready command stream into single
//             APB transfers (one outstanding) and returns each result on a
//             valid/ready response channel. A programmable timeout aborts a
//             transfer whose slave keeps PREADY low.
//  Ports    : PCLK, PRESET          - clock, async active-high reset
//             cmd_*                 - command channel (valid/ready)
//             rsp_*                 - response channel (valid/ready)
//             PSEL..PSTRB           - APB request outputs
//             PREADY/PRDATA/PSLVERR - APB completion inputs
//  Revision : 1.0 - initial release
// ============================================================================
module apb_mst_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  // command channel
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
  // response channel
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  // APB requester side
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_WIDTH-1:0]     PADDR,
  output logic [DATA_WIDTH-1:0]     PWDATA,
  output logic [DATA_WIDTH/8-1:0]   PSTRB,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [DATA_WIDTH-1:0]     PRDATA
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Counter must be able to hold TIMEOUT_CYCLES itself.
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_abort;

  // Ready is withheld while reset is asserted even though the state reads IDLE.
  assign cmd_ready = (r_state == ST_IDLE) && !PRESET;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        // PREADY on the limit edge wins over the timeout.
        if (PREADY) begin
          w_done       = 1'b1;
          w_state_next = ST_RESP;
        end else if (TIMEOUT_EN && (w_cnt_inc == CNT_LIMIT)) begin
          w_abort      = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // APB request registers and response registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        PSEL   <= 1'b1;
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        // Reads present neutral write data and no active lanes.
        PWDATA <= cmd_write ? cmd_wdata : '0;
        PSTRB  <= cmd_write ? cmd_strb  : {STRB_WIDTH{1'b0}};
        r_cnt  <= '0;
      end

      if (r_state == ST_SETUP) begin
        PENABLE <= 1'b1;
      end

      if (w_done) begin
        PSEL        <= 1'b0;
        PENABLE     <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        PSEL        <= 1'b0;
        PENABLE     <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end else if (r_state == ST_ACCESS) begin
        r_cnt <= w_cnt_inc;
      end

      if ((r_state == ST_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_mst_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_mst_bridge
//  Purpose  : Self-checking bench for apb_mst_bridge. Directed vector table
//             plus randomized transfers against a rule-level reference model,
//             and a hand-written mid-transfer reset sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_mst_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;
  logic [DW-1:0] PRDATA = '0;

  int n_pass  = 0;
  int n_total = 0;

  apb_mst_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .PRDATA      (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;     // ACCESS cycles with PREADY low before it rises
    logic          slverr;
    logic [DW-1:0] prdata;
    int            hold;      // cycles the response is back-pressured
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_en;    // cycles with PENABLE high
    int            exp_lat;   // negedges from handshake to rsp_valid seen
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: derives the outcome from the transfer rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   tmo;
    r         = v;
    tmo       = (v.waits >= TMO);
    r.exp_to  = tmo;
    r.exp_err = tmo || v.slverr;
    r.exp_rdata = (tmo || v.write) ? '0 : v.prdata;
    r.exp_en  = tmo ? TMO : v.waits + 1;
    r.exp_lat = r.exp_en + 2;
    return r;
  endfunction

  task automatic run_xfer(input vec_t v, input string tag);
    int            en, lat, bad, hbad;
    bit            seen;
    logic [DW-1:0] exp_wd;
    logic [SW-1:0] exp_st;
    exp_wd = v.write ? v.wdata : '0;
    exp_st = v.write ? v.strb  : '0;

    @(negedge PCLK);
    chk({tag, ":cmd_ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_strb = v.strb; rsp_ready = 1'b0;

    @(negedge PCLK);   // SETUP
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = SW'($urandom);
    cmd_write = ~v.write;
    chk({tag, ":setup_sel_en"}, {PSEL, PENABLE}, 2'b10);
    chk({tag, ":setup_addr"}, PADDR, v.addr);
    chk({tag, ":setup_write"}, PWRITE, v.write);
    chk({tag, ":setup_wdata"}, PWDATA, exp_wd);
    chk({tag, ":setup_strb"}, PSTRB, exp_st);
    chk({tag, ":setup_cmd_ready"}, cmd_ready, 0);

    lat = 1; en = 0; bad = 0; seen = 0;
    for (int k = 0; k < TMO + 8; k++) begin
      @(negedge PCLK);
      lat++;
      if (rsp_valid) begin
        seen = 1;
        break;
      end
      if (!(PSEL && PENABLE) || PADDR !== v.addr || PWRITE !== v.write ||
          PWDATA !== exp_wd || PSTRB !== exp_st || cmd_ready !== 1'b0) bad++;
      PREADY  = (en >= v.waits);
      PSLVERR = PREADY ? v.slverr : 1'($urandom);
      PRDATA  = PREADY ? v.prdata : $urandom;
      en++;
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;

    chk({tag, ":rsp_seen"}, seen, 1);
    chk({tag, ":access_stable"}, bad, 0);
    chk({tag, ":penable_cycles"}, en, v.exp_en);
    chk({tag, ":latency"}, lat, v.exp_lat);
    chk({tag, ":sel_dropped"}, {PSEL, PENABLE}, 2'b00);
    chk({tag, ":rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, ":rsp_err"}, rsp_err, v.exp_err);
    chk({tag, ":rsp_timeout"}, rsp_timeout, v.exp_to);

    // Back-pressure: response must hold and a pending command must wait.
    hbad = 0;
    for (int h = 0; h < v.hold; h++) begin
      cmd_valid = 1'b1;
      @(negedge PCLK);
      if (rsp_valid !== 1'b1 || rsp_rdata !== v.exp_rdata || rsp_err !== v.exp_err ||
          rsp_timeout !== v.exp_to || PSEL !== 1'b0 || cmd_ready !== 1'b0) hbad++;
    end
    if (v.hold > 0) chk({tag, ":rsp_hold"}, hbad, 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk({tag, ":rsp_cleared"}, {rsp_valid, PSEL, cmd_ready}, 3'b001);
  endtask

  vec_t tbl [8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //          wr  addr          wdata         strb  wt slv prdata        hold exp_rdata     err to en lat
    tbl[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,        0, 32'h0,        1'b0, 1'b0, 1, 3};
    tbl[1] = '{1'b0, 32'h10,       32'h11111111, 4'hF, 3, 1'b0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 1'b0, 4, 6};
    tbl[2] = '{1'b1, 32'h24,       32'hCAFEF00D, 4'h3, 0, 1'b1, 32'h0,        5, 32'h0,        1'b1, 1'b0, 1, 3};
    tbl[3] = '{1'b0, 32'h40,       32'h0,        4'h0, 40,1'b0, 32'h5555AAAA, 1, 32'h0,        1'b1, 1'b1, 16, 18};
    tbl[4] = '{1'b1, 32'h44,       32'h01234567, 4'hF, 0, 1'b0, 32'h0,        0, 32'h0,        1'b0, 1'b0, 1, 3};
    tbl[5] = '{1'b0, 32'h80,       32'h0,        4'hF, 15,1'b1, 32'h12345678, 0, 32'h12345678, 1'b1, 1'b0, 16, 18};
    tbl[6] = '{1'b1, 32'h1233,     32'hA5A5A5A5, 4'h5, 2, 1'b0, 32'hFFFFFFFF, 2, 32'h0,        1'b0, 1'b0, 3, 5};
    tbl[7] = '{1'b0, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 1'b0, 1'b0, 1, 3};

    // Reset state.
    #2;
    chk("reset_apb_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("reset_apb_data", {PADDR, PWDATA, PSTRB}, '0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    @(negedge PCLK);
    PRESET = 1'b0;

    for (int i = 0; i < 8; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted in the middle of ACCESS.
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h55; PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("midrst_in_access", {PSEL, PENABLE}, 2'b11);
    #1 PRESET = 1'b1;
    #1;
    chk("midrst_sel_en_async", {PSEL, PENABLE}, 2'b00);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready_in_reset", cmd_ready, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("midrst_cmd_ready_after", cmd_ready, 1);
    chk("midrst_no_rsp", {rsp_valid, PSEL}, 2'b00);
    chk("midrst_paddr_cleared", PADDR, 0);

    // Randomized transfers checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.write  = 1'($urandom);
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.strb   = SW'($urandom);
      v.waits  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO - 2, TMO + 2))
                                             : int'($urandom_range(0, 4));
      v.slverr = 1'($urandom);
      v.prdata = $urandom;
      v.hold   = int'($urandom_range(0, 3));
      v = model(v);
      run_xfer(v, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
